booth_product_accumulator: RTL and testbench
============================================

# booth_product_accumulator

Streaming accumulator that sits directly downstream of the 32x32 signed Booth multiplier. It takes one signed 64-bit product per accepted beat and sums a burst of products, delimited by `in_last`, in a widened internal accumulator. It emits one saturated signed 64-bit sum per burst over a valid/ready handshake, turning the combinational multiplier into a dot-product / MAC stage.

## Interface
Parameters:
- `PROD_W`, 64, width of the incoming signed product and of the outgoing sum.
- `GUARD_W`, 8, guard bits in the internal accumulator (accumulator width is `PROD_W+GUARD_W`).
- `MAX_TERMS`, 256, maximum products per burst; must be ≤ 2^GUARD_W.
- `CNT_W`, 9, term-counter width; must satisfy 2^CNT_W > MAX_TERMS.

Ports:
- `clk`, in, 1, the single clock; all logic is rising-edge.
- `rst_n`, in, 1, synchronous active-low reset, sampled on `clk`.
- `in_valid`, in, 1, `in_product` / `in_last` are valid.
- `in_ready`, out, 1, block can accept a product this cycle.
- `in_product`, in, PROD_W, signed product from the multiplier.
- `in_last`, in, 1, final product of the current burst.
- `out_valid`, out, 1, `out_sum` and its flags are valid.
- `out_ready`, in, 1, consumer takes the result.
- `out_sum`, out, PROD_W, signed sum, saturated to PROD_W.
- `out_sat`, out, 1, true sum was outside the PROD_W signed range.
- `out_forced`, out, 1, burst was closed by `MAX_TERMS`, not by `in_last`.
- `out_count`, out, CNT_W, number of products in the burst.

## Operation
- There are two states: `ACCUM` (reset state) and `HOLD`.
- **`ACCUM` state:**
  - `in_ready`=1.
  - An accept is `in_valid && in_ready`.
  - Each accept adds `acc += sign-extended in_product` and increments `count`.
- **Leaving `ACCUM`:**
  - An accept with `in_last`=1 closes the burst and moves to `HOLD`.
  - An accept that brings `count` to `MAX_TERMS` with `in_last`=0 also closes the burst, sets `out_forced`=1, and moves to `HOLD`.
- **`HOLD` state:**
  - `in_ready`=0 and `out_valid`=1.
  - `out_sum`, `out_sat`, `out_forced` and `out_count` are registered and stable.
  - On `out_valid && out_ready`: clear `acc`, `count` and the flags, then go to `ACCUM`.
- **Saturation:**
  - If `acc` > 2^(PROD_W-1)-1, `out_sum`=0x7FFF_FFFF_FFFF_FFFF.
  - If `acc` < -2^(PROD_W-1), `out_sum`=0x8000_0000_0000_0000.
  - Otherwise `out_sum` = `acc`[PROD_W-1:0].
  - `out_sat` is set whenever clamping occurred.
- The guard bits make internal overflow impossible for bursts of up to `MAX_TERMS`.
- A single-product burst (`in_last` on the first beat) is legal; its `out_count` is 1.
- `in_product` and `in_last` are ignored when `in_valid`=0.

## Timing
- **Reset:** while `rst_n`=0 at an edge:
  - State goes to `ACCUM`; `acc` and `count` go to 0.
  - `out_valid`, `out_sum`, `out_sat`, `out_forced` and `out_count` all go to 0.
  - `in_ready` is forced to 0 while `rst_n` is low.
- **Reset mid-burst or mid-`HOLD`:** the partial sum or pending result is discarded, with no output.
- **Latency:** `out_valid` rises on the edge after the closing accept (one cycle).
- **Throughput:** one product per cycle in `ACCUM`.
- **Dead cycles:** `HOLD` lasts at least one cycle, so there is at least one dead input cycle per burst.
- **Handshake rules:**
  - `out_*` must not change while `out_valid`=1 and `out_ready`=0.
  - `in_ready` does not depend combinationally on `out_ready`; it is a function of state and `rst_n` only.
- **Result-accept cycle:** if `out_ready`=1 in the first `HOLD` cycle, `in_ready` returns to 1 on the following cycle. No new product is accepted in the same cycle a result is taken.

## Structure
- Shared package `booth_pkg` holds:
  - `PROD_W` and the operand width (32).
  - The state enum `acc_state_t` {ACCUM, HOLD}.
  - The saturation limit constants.
- Sub-module `booth_sat_clamp`, which is combinational:
  - Input: the (PROD_W+GUARD_W)-bit signed value.
  - Outputs: the PROD_W-bit clamped value and the `sat` flag.
  - It is reusable by later stages.

## Test plan
- **Basic sum:** products 5, -3, 10 (last), `out_ready`=1 → `out_sum`=12, `out_count`=3, `out_sat`=0, `out_forced`=0, one cycle after the last accept.
- **Positive saturation:** 0x7FFF_FFFF_FFFF_FFFF twice (last) → `out_sum`=0x7FFF_FFFF_FFFF_FFFF, `out_sat`=1.
- **Negative saturation:** 0x8000_0000_0000_0000, then -1 (last) → `out_sum`=0x8000_0000_0000_0000, `out_sat`=1.
- **Recovery inside the guard range:** 0x7FFF_FFFF_FFFF_FFFF, 1, -1 (last) → `out_sum`=0x7FFF_FFFF_FFFF_FFFF, `out_sat`=0.
- **Backpressure:** single product 7 (last), `out_ready` low for 5 cycles while `in_valid` is held high with product 9:
  - Outputs stay stable and `in_ready`=0 throughout.
  - Product 9 is accepted only after the result handshake.
- **Forced close:** 256 products of value 1 with `in_last`=0 → `out_sum`=256, `out_count`=256, `out_forced`=1.
- **Reset mid-burst:** `rst_n` low after 2 products → no `out_valid`; the next burst {4 (last)} yields `out_sum`=4, `out_count`=1.

Source files
------------

// File: rtl/booth_pkg.sv
// booth_pkg: shared widths, accumulator state encoding and saturation limits
package booth_pkg;
  localparam int PROD_W = 64;
  localparam int OP_W = 32;
  typedef enum logic {ACCUM, HOLD} acc_state_t;
  localparam logic [PROD_W-1:0] SAT_POS = {1'b0, {(PROD_W-1){1'b1}}};
  localparam logic [PROD_W-1:0] SAT_NEG = {1'b1, {(PROD_W-1){1'b0}}};
endpackage

// File: rtl/booth_sat_clamp.sv
// booth_sat_clamp: clamps a guard-widened signed value to W signed bits
module booth_sat_clamp #(
  parameter int W = 64,
  parameter int G = 8
) (
  input  logic [W+G-1:0] i_val,
  output logic [W-1:0]   o_val,
  output logic           o_sat
);
  logic [G:0] w_top;
  always_comb begin
    w_top = i_val[W+G-1:W-1];
    o_sat = !((&w_top) || !(|w_top));
    o_val = !o_sat ? i_val[W-1:0] :
            i_val[W+G-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end
endmodule

// File: rtl/booth_product_accumulator.sv
// booth_product_accumulator: sums bursts of signed products, emits one saturated sum per burst
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W    = 64,
  parameter int GUARD_W   = 8,
  parameter int MAX_TERMS = 256,
  parameter int CNT_W     = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_sum,
  output logic              out_sat,
  output logic              out_forced,
  output logic [CNT_W-1:0]  out_count
);
  localparam int ACC_W = PROD_W + GUARD_W;
  acc_state_t r_state, w_state_nxt;
  logic [ACC_W-1:0]  r_acc, w_acc_nxt;
  logic [CNT_W-1:0]  r_count, w_cnt_nxt;
  logic [PROD_W-1:0] r_sum, w_clamped;
  logic              r_sat, r_forced, w_sat, w_accept, w_close, w_take;
  booth_sat_clamp #(.W(PROD_W), .G(GUARD_W)) u_clamp (
    .i_val(w_acc_nxt),
    .o_val(w_clamped),
    .o_sat(w_sat)
  );
  always_comb begin
    in_ready    = rst_n && (r_state == ACCUM);
    out_valid   = (r_state == HOLD);
    w_accept    = in_valid && in_ready;
    w_take      = out_valid && out_ready;
    w_acc_nxt   = r_acc + {{GUARD_W{in_product[PROD_W-1]}}, in_product};
    w_cnt_nxt   = r_count + CNT_W'(1);
    w_close     = w_accept && (in_last || (w_cnt_nxt == CNT_W'(MAX_TERMS)));
    w_state_nxt = r_state;
    if (w_close) w_state_nxt = HOLD;
    else if (w_take) w_state_nxt = ACCUM;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ACCUM;
      r_acc    <= '0;
      r_count  <= '0;
      r_sum    <= '0;
      r_sat    <= 1'b0;
      r_forced <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_acc   <= w_acc_nxt;
        r_count <= w_cnt_nxt;
      end
      if (w_close) begin
        r_sum    <= w_clamped;
        r_sat    <= w_sat;
        r_forced <= !in_last;
      end
      if (w_take) begin
        r_acc    <= '0;
        r_count  <= '0;
        r_sum    <= '0;
        r_sat    <= 1'b0;
        r_forced <= 1'b0;
      end
    end
  end
  assign out_sum    = r_sum;
  assign out_sat    = r_sat;
  assign out_forced = r_forced;
  assign out_count  = r_count;
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb_booth_product_accumulator: random and directed bursts checked by a queue-based scoreboard
module tb_booth_product_accumulator;
  import booth_pkg::*;
  typedef struct {
    logic [63:0] sum;
    logic        sat;
    logic        forced;
    logic [8:0]  cnt;
  } exp_t;
  logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
  logic        in_ready, out_valid, out_sat, out_forced;
  logic [63:0] in_product = '0, out_sum;
  logic [8:0]  out_count;
  int          n_chk = 0, n_fail = 0;
  bit          rdy_low = 0, rdy_rand = 0;
  exp_t        sb[$];
  logic signed [127:0] m_acc = 0;
  int          m_cnt = 0;
  booth_product_accumulator dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_sat(out_sat),
    .out_forced(out_forced), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference: accumulate in a wide integer, close on last or at 256 terms, clamp to 64-bit range
  task automatic model_accept(longint p, bit last);
    exp_t e;
    m_acc = m_acc + 128'(p);
    m_cnt++;
    if (last || m_cnt == 256) begin
      e.sat    = (m_acc > 128'(longint'(SAT_POS))) || (m_acc < 128'(longint'(SAT_NEG)));
      e.sum    = (m_acc > 128'(longint'(SAT_POS))) ? SAT_POS :
                 (m_acc < 128'(longint'(SAT_NEG))) ? SAT_NEG : m_acc[63:0];
      e.forced = !last;
      e.cnt    = 9'(m_cnt);
      sb.push_back(e);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask
  task automatic send(logic [63:0] p, bit last);
    int t = 0;
    bit closes;
    in_valid = 1; in_product = p; in_last = last;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", t);
    end
    closes = last || (m_cnt + 1 == 256);
    @(posedge clk);
    model_accept(longint'(p), last);
    @(negedge clk);
    in_valid = 0;
    if (closes) chk("latency_out_valid", 64'(out_valid), 64'd1);
  endtask
  always @(posedge clk) begin
    #2;
    out_ready = rdy_low ? 1'b0 : rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: out_valid=1 sum %h with no result expected", out_sum);
      end else begin
        chk("out_sum", out_sum, sb[0].sum);
        chk("out_sat", 64'(out_sat), 64'(sb[0].sat));
        chk("out_forced", 64'(out_forced), 64'(sb[0].forced));
        chk("out_count", 64'(out_count), 64'(sb[0].cnt));
        chk("in_ready_in_hold", 64'(in_ready), 64'd0);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end
  initial begin
    int t;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_sum", out_sum, 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    send(64'd5, 0); send(-64'sd3, 0); send(64'd10, 1);
    send(SAT_POS, 0); send(SAT_POS, 1);
    send(SAT_NEG, 0); send(-64'sd1, 1);
    send(SAT_POS, 0); send(64'd1, 0); send(-64'sd1, 1);
    rdy_low = 1;
    send(64'd7, 1);
    fork begin repeat (5) @(posedge clk); rdy_low = 0; end join_none
    send(64'd9, 1);
    for (int i = 0; i < 256; i++) send(64'd1, 0);
    send(64'd1, 0); send(64'd2, 0);
    rst_n = 0;
    m_acc = 0; m_cnt = 0;
    repeat (2) begin
      @(negedge clk);
      chk("midrst_in_ready", 64'(in_ready), 64'd0);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
    end
    rst_n = 1;
    @(negedge clk);
    send(64'd4, 1);
    rdy_rand = 1;
    for (int b = 0; b < 25; b++) begin
      int len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        logic [63:0] p;
        case ($urandom_range(0, 3))
          0: p = SAT_POS;
          1: p = SAT_NEG;
          2: p = 64'($signed($urandom_range(0, 2000)) - 1000);
          default: p = {$urandom, $urandom};
        endcase
        send(p, k == len - 1);
      end
    end
    rdy_rand = 0;
    t = 0;
    while (sb.size() != 0 && t < 200) begin @(negedge clk); t++; end
    if (sb.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain: %0d results never presented, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
